// File: rtl/snake_pkg.sv
// Shared definitions for the snake trail renderer.
//   COORD_W       : width of a screen coordinate held in the history
//   SEG_SIZE_DEF  : default segment box edge in pixels
//   HEAD/BODY/BG  : RGB565 colour defaults
//   seg_t         : one history entry, {x, y}
package snake_pkg;

    localparam int COORD_W      = 9;
    localparam int SEG_SIZE_DEF = 4;

    localparam logic [15:0] HEAD_RGB = 16'hF800;
    localparam logic [15:0] BODY_RGB = 16'h07E0;
    localparam logic [15:0] BG_RGB   = 16'h0000;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
    } seg_t;

endpackage

// File: rtl/snake_trail_renderer_if.sv
// Bus between the head-motion / OLED scan side and the trail renderer.
//   master : drives head_tick, head_x, head_y, grow, pixel_x, pixel_y
//            and receives pixel_colour, length, self_hit
//   slave  : the renderer side (mirror of master)
interface snake_trail_renderer_if #(
    parameter int MAX_SEGS = 16
);
    localparam int LEN_W = $clog2(MAX_SEGS) + 1;

    logic                            head_tick;
    logic [snake_pkg::COORD_W-1:0]   head_x;
    logic [snake_pkg::COORD_W-1:0]   head_y;
    logic                            grow;
    logic [7:0]                      pixel_x;
    logic [7:0]                      pixel_y;
    logic [15:0]                     pixel_colour;
    logic [LEN_W-1:0]                length;
    logic                            self_hit;

    modport master (
        output head_tick, head_x, head_y, grow, pixel_x, pixel_y,
        input  pixel_colour, length, self_hit
    );

    modport slave (
        input  head_tick, head_x, head_y, grow, pixel_x, pixel_y,
        output pixel_colour, length, self_hit
    );
endinterface

// File: rtl/seg_box_hit.sv
// Combinational test: does pixel (px,py) fall inside the SEG_SIZE box whose
// top-left corner is (sx,sy)? Lower edges are exclusive, upper inclusive.
//   px, py : pixel coordinate (zero-extended by the caller to COORD_W)
//   sx, sy : segment top-left
//   hit    : 1 when the pixel lies in the box
module seg_box_hit
    import snake_pkg::*;
#(
    parameter int SEG_SIZE = SEG_SIZE_DEF
) (
    input  logic [COORD_W-1:0] px,
    input  logic [COORD_W-1:0] py,
    input  logic [COORD_W-1:0] sx,
    input  logic [COORD_W-1:0] sy,
    output logic               hit
);
    // One extra bit so sx+SEG_SIZE cannot wrap for sx up to 511.
    localparam logic [COORD_W:0] SZ = (COORD_W+1)'(SEG_SIZE);

    logic [COORD_W:0] px_w, py_w, sx_w, sy_w;

    assign px_w = {1'b0, px};
    assign py_w = {1'b0, py};
    assign sx_w = {1'b0, sx};
    assign sy_w = {1'b0, sy};

    assign hit = (px_w > sx_w) && (px_w <= sx_w + SZ) &&
                 (py_w > sy_w) && (py_w <= sy_w + SZ);
endmodule

// File: rtl/snake_trail_renderer.sv
// Snake body renderer: keeps a circular history of head positions, grows
// the drawable length on food, flags self-collision, and produces the
// registered RGB565 colour for the pixel currently being scanned.
//   clk, reset : clock, asynchronous active-high reset
//   bus.slave  : head_tick/head_x/head_y/grow/pixel_x/pixel_y in,
//                pixel_colour (1 clk latency), length, self_hit out
module snake_trail_renderer
    import snake_pkg::*;
#(
    parameter int          MAX_SEGS    = 16,
    parameter int          INIT_LEN    = 3,
    parameter int          GROW_STEP   = 2,
    parameter int          SEG_SIZE    = SEG_SIZE_DEF,
    parameter int          NECK_SKIP   = 2,
    parameter logic [15:0] HEAD_COLOUR = HEAD_RGB,
    parameter logic [15:0] BODY_COLOUR = BODY_RGB,
    parameter logic [15:0] BG_COLOUR   = BG_RGB
) (
    input logic                    clk,
    input logic                    reset,
    snake_trail_renderer_if.slave  bus
);
    localparam int PTR_W = $clog2(MAX_SEGS);
    localparam int LEN_W = PTR_W + 1;

    localparam logic [LEN_W-1:0]   LEN_MAX  = LEN_W'(MAX_SEGS);
    localparam logic [LEN_W-1:0]   LEN_INIT = LEN_W'(INIT_LEN);
    localparam logic signed [COORD_W:0] SEG_S = (COORD_W+1)'(SEG_SIZE);

    // Saturating length increase for a grow pulse.
    function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
        logic [LEN_W:0] sum;
        sum = {1'b0, len} + (LEN_W+1)'(GROW_STEP);
        if (sum > {1'b0, LEN_MAX})
            return LEN_MAX;
        return sum[LEN_W-1:0];
    endfunction

    // True when |a-b| < SEG_SIZE.
    function automatic logic near(input logic [COORD_W-1:0] a,
                                  input logic [COORD_W-1:0] b);
        logic signed [COORD_W:0] d;
        d = $signed({1'b0, a}) - $signed({1'b0, b});
        return (d < SEG_S) && (d > -SEG_S);
    endfunction

    seg_t               hist [MAX_SEGS];
    logic [PTR_W-1:0]   wr_ptr;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   length_q;
    logic [COORD_W-1:0] last_x, last_y;
    logic [15:0]        colour_p1;
    logic               self_hit_p1;

    logic               push;
    seg_t               age_seg  [MAX_SEGS];
    logic [MAX_SEGS-1:0] age_live;
    logic [MAX_SEGS-1:0] box_hit;
    logic [MAX_SEGS-1:0] overlap;
    logic               head_hit;
    logic               body_hit;
    logic               collide;
    logic [15:0]        colour_next;

    assign push = bus.head_tick &&
                  ((fill == '0) || (bus.head_x != last_x) || (bus.head_y != last_y));

    // View the ring by age: k=0 is the newest entry.
    for (genvar k = 0; k < MAX_SEGS; k++) begin : g_age
        assign age_seg[k]  = hist[wr_ptr - PTR_W'(k + 1)];
        assign age_live[k] = (LEN_W'(k) < fill) && (LEN_W'(k) < length_q);

        seg_box_hit #(.SEG_SIZE(SEG_SIZE)) u_body_box (
            .px  ({1'b0, bus.pixel_x}),
            .py  ({1'b0, bus.pixel_y}),
            .sx  (age_seg[k].x),
            .sy  (age_seg[k].y),
            .hit (box_hit[k])
        );

        if (k >= NECK_SKIP) begin : g_chk
            assign overlap[k] = age_live[k] &&
                                near(bus.head_x, age_seg[k].x) &&
                                near(bus.head_y, age_seg[k].y);
        end else begin : g_neck
            assign overlap[k] = 1'b0;
        end
    end

    seg_box_hit #(.SEG_SIZE(SEG_SIZE)) u_head_box (
        .px  ({1'b0, bus.pixel_x}),
        .py  ({1'b0, bus.pixel_y}),
        .sx  (bus.head_x),
        .sy  (bus.head_y),
        .hit (head_hit)
    );

    // Entry k=0 sits under the head after a push, so it is never drawn as body.
    assign body_hit = |(box_hit & age_live & ~MAX_SEGS'(1));
    assign collide  = push && (|overlap);

    always_comb begin
        colour_next = BG_COLOUR;
        if (body_hit)
            colour_next = BODY_COLOUR;
        if (head_hit)
            colour_next = HEAD_COLOUR;
    end

    // History storage carries no reset; fill masks stale entries.
    always_ff @(posedge clk) begin
        if (push)
            hist[wr_ptr] <= '{x: bus.head_x, y: bus.head_y};
    end

    // Stage p1: control state and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            fill        <= '0;
            last_x      <= '0;
            last_y      <= '0;
            length_q    <= LEN_INIT;
            colour_p1   <= BG_COLOUR;
            self_hit_p1 <= 1'b0;
        end else begin
            colour_p1   <= colour_next;
            self_hit_p1 <= collide;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                last_x <= bus.head_x;
                last_y <= bus.head_y;
                if (fill != LEN_MAX)
                    fill <= fill + LEN_W'(1);
            end
            if (bus.grow)
                length_q <= sat_len(length_q);
        end
    end

    assign bus.pixel_colour = colour_p1;
    assign bus.length       = length_q;
    assign bus.self_hit     = self_hit_p1;
endmodule

// File: tb/tb_snake_trail_renderer.sv
// Directed bench for snake_trail_renderer with a queue-based reference model.
module tb_snake_trail_renderer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    snake_trail_renderer_if #(.MAX_SEGS(16)) bus ();

    snake_trail_renderer #(.MAX_SEGS(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: newest position at index 0, at most 16 kept.
    int qx[$];
    int qy[$];
    int m_len;

    logic [15:0] exp_colour;
    int          exp_len;
    logic        exp_hit;
    bit          chk_en = 1'b0;

    function automatic bit in_box(int px, int py, int sx, int sy);
        return (px > sx) && (px <= sx + 4) && (py > sy) && (py <= sy + 4);
    endfunction

    task automatic check(string name, int act, int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic model_reset();
        qx.delete();
        qy.delete();
        m_len = 3;
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_colour", int'(bus.pixel_colour), int'(exp_colour));
            check("model_length", int'(bus.length), exp_len);
            check("model_self_hit", int'(bus.self_hit), int'(exp_hit));
        end
    end

    task automatic step(bit tick, int hx, int hy, bit gr, int px, int py);
        bit push;
        bit body;
        @(negedge clk);
        #1;
        bus.head_tick = tick;
        bus.head_x    = 9'(hx);
        bus.head_y    = 9'(hy);
        bus.grow      = gr;
        bus.pixel_x   = 8'(px);
        bus.pixel_y   = 8'(py);

        body = 1'b0;
        for (int k = 1; k < qx.size() && k < m_len; k++)
            if (in_box(px, py, qx[k], qy[k])) body = 1'b1;
        if (in_box(px, py, hx, hy))
            exp_colour = 16'hF800;
        else if (body)
            exp_colour = 16'h07E0;
        else
            exp_colour = 16'h0000;

        push = tick && (qx.size() == 0 || hx != qx[0] || hy != qy[0]);
        exp_hit = 1'b0;
        if (push) begin
            for (int k = 2; k < m_len && k < qx.size(); k++) begin
                int dx, dy;
                dx = hx - qx[k];
                dy = hy - qy[k];
                if (dx < 4 && dx > -4 && dy < 4 && dy > -4) exp_hit = 1'b1;
            end
        end
        if (gr)
            m_len = (m_len + 2 > 16) ? 16 : m_len + 2;
        if (push) begin
            qx.push_front(hx);
            qy.push_front(hy);
            if (qx.size() > 16) begin
                void'(qx.pop_back());
                void'(qy.pop_back());
            end
        end
        exp_len = m_len;
        chk_en  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        reset  = 1'b1;
        model_reset();
        #1;
        check("rst_colour", int'(bus.pixel_colour), 'h0000);
        check("rst_length", int'(bus.length), 3);
        check("rst_self_hit", int'(bus.self_hit), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;
    endtask

    int grow_exp [8] = '{5, 7, 9, 11, 13, 15, 16, 16};

    initial begin
        bus.head_tick = 1'b0;
        bus.head_x    = '0;
        bus.head_y    = '0;
        bus.grow      = 1'b0;
        bus.pixel_x   = '0;
        bus.pixel_y   = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_colour", int'(bus.pixel_colour), 'h0000);
        check("reset_length", int'(bus.length), 3);
        check("reset_self_hit", int'(bus.self_hit), 0);
        @(negedge clk);
        #1;
        reset = 1'b0;

        // Lone head box edges, empty history.
        step(0, 45, 30, 0, 46, 31);
        check("head_inside", int'(bus.pixel_colour), 'hF800);
        step(0, 45, 30, 0, 45, 30);
        check("head_low_edge", int'(bus.pixel_colour), 'h0000);
        step(0, 45, 30, 0, 49, 34);
        check("head_high_edge", int'(bus.pixel_colour), 'hF800);
        step(0, 45, 30, 0, 50, 34);
        check("head_past_edge", int'(bus.pixel_colour), 'h0000);

        // Four pushes, length 3.
        for (int i = 1; i <= 4; i++) step(1, 10 * i, 10, 0, 0, 0);
        step(0, 40, 10, 0, 31, 11);
        check("body_k1", int'(bus.pixel_colour), 'h07E0);
        step(0, 40, 10, 0, 21, 11);
        check("body_k2", int'(bus.pixel_colour), 'h07E0);
        step(0, 40, 10, 0, 11, 11);
        check("body_k3_hidden", int'(bus.pixel_colour), 'h0000);
        step(0, 40, 10, 0, 41, 11);
        check("head_over_k0", int'(bus.pixel_colour), 'hF800);

        // Stationary head ticks must not shift history.
        repeat (3) step(1, 40, 10, 0, 0, 0);
        step(0, 40, 10, 0, 21, 11);
        check("still_k2", int'(bus.pixel_colour), 'h07E0);
        step(0, 40, 10, 0, 31, 11);
        check("still_k1", int'(bus.pixel_colour), 'h07E0);

        // Mid-operation reset clears history; grow coincident with push.
        do_reset();
        step(0, 200, 200, 0, 31, 11);
        check("cleared", int'(bus.pixel_colour), 'h0000);
        step(1, 100, 100, 1, 0, 0);
        step(1, 110, 100, 0, 0, 0);
        check("grow_push_len", int'(bus.length), 5);
        step(0, 110, 100, 0, 101, 101);
        check("grow_push_body", int'(bus.pixel_colour), 'h07E0);

        // Twenty pushes saturate the ring, then grow to full length.
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 10 + 12 * i, 200, 0, 0, 0);
        for (int j = 0; j < 8; j++) begin
            step(0, 238, 200, 1, 0, 0);
            check("grow_seq", int'(bus.length), grow_exp[j]);
        end
        step(0, 238, 200, 0, 47, 201);
        check("overwritten", int'(bus.pixel_colour), 'h0000);
        step(0, 238, 200, 0, 59, 201);
        check("oldest_kept", int'(bus.pixel_colour), 'h07E0);
        step(0, 238, 200, 0, 227, 201);
        check("newest_body", int'(bus.pixel_colour), 'h07E0);
        step(0, 238, 200, 0, 239, 201);
        check("head_full", int'(bus.pixel_colour), 'hF800);

        // Loop back onto entry k=4, then touch only the neck.
        do_reset();
        step(0, 0, 0, 1, 0, 0);
        step(1, 100, 100, 0, 0, 0);
        step(1, 108, 100, 0, 0, 0);
        step(1, 116, 100, 0, 0, 0);
        step(1, 116, 108, 0, 0, 0);
        step(1, 108, 108, 0, 0, 0);
        check("no_hit_yet", int'(bus.self_hit), 0);
        step(1, 101, 103, 0, 0, 0);
        check("self_hit", int'(bus.self_hit), 1);
        step(0, 101, 103, 0, 0, 0);
        check("self_hit_one_clk", int'(bus.self_hit), 0);
        step(1, 110, 110, 0, 0, 0);
        check("neck_ignored", int'(bus.self_hit), 0);
        step(0, 110, 110, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
